func_code_router: RTL and testbench

//  Parametrised successor of the 6-bit function-code demux: registered router that takes a

---
 rtl/func_code_router.sv | 128 ++++++++++++
 tb/tb_func_code_router.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/func_code_router.sv
// Registered function-code router: one request at a time is delivered to a single channel
// and held until that channel acks or the ack timeout expires. Build option: FCR_HOLD_LAST_EN.
module func_code_router #(
    parameter int                 NUM_CH    = 2,
    parameter int                 FUNC_W    = 3,
    parameter int                 SEL_W     = 1,
    parameter logic [FUNC_W-1:0]  IDLE_CODE = '0,
    parameter int                 TIMEOUT   = 15
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [SEL_W-1:0]         in_sel,
    input  logic [FUNC_W-1:0]        in_code,
    output logic [NUM_CH*FUNC_W-1:0] ch_code,
    output logic [NUM_CH-1:0]        ch_valid,
    input  logic [NUM_CH-1:0]        ch_ack,
    output logic                     busy,
    output logic                     err_sel,
    output logic                     err_timeout
);

    // state    | meaning
    // IDLE     | ready for a request, no channel strobed
    // WAIT_ACK | one channel strobed, waiting for its ack or the timeout
    typedef enum logic {IDLE, WAIT_ACK} state_t;

    localparam int                CNT_W    = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [SEL_W:0]    NUM_CH_L = (SEL_W + 1)'(NUM_CH);
    localparam logic [CNT_W-1:0]  CNT_LAST = (TIMEOUT > 0) ? CNT_W'(TIMEOUT - 1) : '0;
    localparam logic [CNT_W-1:0]  CNT_MAX  = '1;
    localparam logic [NUM_CH*FUNC_W-1:0] IDLE_ALL = {NUM_CH{IDLE_CODE}};

    state_t                    state, state_d;
    logic [SEL_W-1:0]          sel_q, sel_d;
    logic [CNT_W-1:0]          cnt, cnt_d;
    logic [NUM_CH*FUNC_W-1:0]  code_d;
    logic [NUM_CH-1:0]         valid_d;
    logic                      err_sel_d, err_to_d;
    logic                      ack_hit;
    logic                      release_ch;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            sel_q       <= '0;
            cnt         <= '0;
            ch_code     <= IDLE_ALL;
            ch_valid    <= '0;
            err_sel     <= 1'b0;
            err_timeout <= 1'b0;
        end else begin
            state       <= state_d;
            sel_q       <= sel_d;
            cnt         <= cnt_d;
            ch_code     <= code_d;
            ch_valid    <= valid_d;
            err_sel     <= err_sel_d;
            err_timeout <= err_to_d;
        end
    end

    always_comb begin
        state_d    = state;
        sel_d      = sel_q;
        cnt_d      = cnt;
        code_d     = ch_code;
        valid_d    = ch_valid;
        err_sel_d  = 1'b0;
        err_to_d   = 1'b0;
        ack_hit    = 1'b0;
        release_ch = 1'b0;

        // only the ack of the channel currently being served counts
        for (int i = 0; i < NUM_CH; i++) begin
            if (sel_q == SEL_W'(i)) ack_hit = ch_ack[i];
        end

        case (state)
            IDLE: begin
                if (in_valid) begin
                    if ({1'b0, in_sel} >= NUM_CH_L) begin
                        err_sel_d = 1'b1;
                    end else begin
                        state_d = WAIT_ACK;
                        sel_d   = in_sel;
                        cnt_d   = '0;
                        code_d  = IDLE_ALL;
                        valid_d = '0;
                        for (int i = 0; i < NUM_CH; i++) begin
                            if (in_sel == SEL_W'(i)) begin
                                code_d[i*FUNC_W +: FUNC_W] = in_code;
                                valid_d[i]                 = 1'b1;
                            end
                        end
                    end
                end
            end
            WAIT_ACK: begin
                // ack takes priority so an ack on the last counted cycle is not an error
                if (ack_hit) begin
                    release_ch = 1'b1;
                end else if (TIMEOUT > 0 && cnt == CNT_LAST) begin
                    release_ch = 1'b1;
                    err_to_d   = 1'b1;
                end else if (cnt != CNT_MAX) begin
                    cnt_d = cnt + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

        if (release_ch) begin
            state_d = IDLE;
            valid_d = '0;
`ifdef FCR_HOLD_LAST_EN
            code_d  = ch_code;
`else
            code_d  = IDLE_ALL;
`endif
        end
    end

    assign in_ready = (state == IDLE);
    assign busy     = ~in_ready;

endmodule

// File: tb/tb_func_code_router.sv
// Directed bench for func_code_router: a 2-channel instance (TIMEOUT=4) and a 3-channel
// instance for select-range errors; expected values are hand-computed per test.
module tb_func_code_router;

    logic       clk = 1'b0;
    logic       rst_n;

    logic       in_valid, in_ready, busy, err_sel, err_timeout;
    logic       in_sel;
    logic [2:0] in_code;
    logic [5:0] ch_code;
    logic [1:0] ch_valid, ch_ack;

    logic       in_valid3, in_ready3, busy3, err_sel3, err_timeout3;
    logic [1:0] in_sel3;
    logic [2:0] in_code3;
    logic [8:0] ch_code3;
    logic [2:0] ch_valid3, ch_ack3;

    int checks   = 0;
    int failures = 0;
    logic saw_err;

    always #5 clk = ~clk;

    func_code_router #(.NUM_CH(2), .FUNC_W(3), .SEL_W(1), .IDLE_CODE(3'b000), .TIMEOUT(4)) u_dut2 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .in_sel(in_sel),
        .in_code(in_code), .ch_code(ch_code), .ch_valid(ch_valid), .ch_ack(ch_ack),
        .busy(busy), .err_sel(err_sel), .err_timeout(err_timeout)
    );

    func_code_router #(.NUM_CH(3), .FUNC_W(3), .SEL_W(2), .IDLE_CODE(3'b000), .TIMEOUT(4)) u_dut3 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid3), .in_ready(in_ready3), .in_sel(in_sel3),
        .in_code(in_code3), .ch_code(ch_code3), .ch_valid(ch_valid3), .ch_ack(ch_ack3),
        .busy(busy3), .err_sel(err_sel3), .err_timeout(err_timeout3)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0;
        in_valid = 0; in_sel = 0; in_code = 0; ch_ack = 0;
        in_valid3 = 0; in_sel3 = 0; in_code3 = 0; ch_ack3 = 0;
        #12;
        check("rst_code", 32'(ch_code), 32'h0);
        check("rst_valid", 32'(ch_valid), 32'h0);
        rst_n = 1'b1;
        step();
        check("rst_ready", 32'(in_ready), 32'h1);
        check("rst_busy", 32'(busy), 32'h0);

        // route sel=1 code=101, ack at T+2
        in_valid = 1; in_sel = 1; in_code = 3'b101;
        step();
        in_valid = 0;
        check("route_code", 32'(ch_code), 32'b101000);
        check("route_valid", 32'(ch_valid), 32'b10);
        check("route_ready", 32'(in_ready), 32'h0);
        check("route_busy", 32'(busy), 32'h1);
        ch_ack = 2'b10;
        step();
        ch_ack = 2'b00;
`ifdef FCR_HOLD_LAST_EN
        check("ack_code", 32'(ch_code), 32'b101000);
`else
        check("ack_code", 32'(ch_code), 32'b000000);
`endif
        check("ack_valid", 32'(ch_valid), 32'h0);
        check("ack_ready", 32'(in_ready), 32'h1);

        // next route to ch0 clears ch1 in either build
        in_valid = 1; in_sel = 0; in_code = 3'b010;
        step();
        in_valid = 0;
        check("route0_code", 32'(ch_code), 32'b000010);
        check("route0_valid", 32'(ch_valid), 32'b01);
        ch_ack = 2'b01;
        step();
        ch_ack = 2'b00;
        check("ack0_valid", 32'(ch_valid), 32'h0);

        // ack while idle is ignored
        ch_ack = 2'b11;
        step();
        ch_ack = 2'b00;
        check("idle_ack_valid", 32'(ch_valid), 32'h0);
        check("idle_ack_ready", 32'(in_ready), 32'h1);

        // timeout: no ack, err at T+5
        in_valid = 1; in_sel = 0; in_code = 3'b011;
        step();
        in_valid = 0;
        check("to_code", 32'(ch_code), 32'b000011);
        check("to_valid_t1", 32'(ch_valid), 32'b01);
        for (int k = 2; k <= 4; k++) begin
            step();
            check($sformatf("to_valid_t%0d", k), 32'(ch_valid), 32'b01);
            check($sformatf("to_noerr_t%0d", k), 32'(err_timeout), 32'h0);
        end
        step();
        check("to_err", 32'(err_timeout), 32'h1);
        check("to_valid_t5", 32'(ch_valid), 32'h0);
        check("to_ready", 32'(in_ready), 32'h1);
`ifdef FCR_HOLD_LAST_EN
        check("to_code_t5", 32'(ch_code), 32'b000011);
`else
        check("to_code_t5", 32'(ch_code), 32'b000000);
`endif
        step();
        check("to_err_pulse", 32'(err_timeout), 32'h0);

        // ack on the last counted cycle wins
        in_valid = 1; in_sel = 0; in_code = 3'b011;
        step();
        in_valid = 0;
        step(); step(); step();
        check("late_valid_t4", 32'(ch_valid), 32'b01);
        ch_ack = 2'b01;
        step();
        ch_ack = 2'b00;
        check("late_noerr", 32'(err_timeout), 32'h0);
        check("late_valid", 32'(ch_valid), 32'h0);

        // wrong-channel ack ignored, request changes while busy ignored
        in_valid = 1; in_sel = 0; in_code = 3'b110;
        step();
        ch_ack = 2'b10; in_valid = 1; in_sel = 1; in_code = 3'b111;
        step();
        check("wrong_ack_valid", 32'(ch_valid), 32'b01);
        check("busy_code_hold", 32'(ch_code), 32'b000110);
        in_valid = 0;
        step();
        check("wrong_ack_valid2", 32'(ch_valid), 32'b01);
        ch_ack = 2'b01;
        step();
        ch_ack = 2'b00;
        check("right_ack_valid", 32'(ch_valid), 32'h0);
        check("right_ack_noerr", 32'(err_timeout), 32'h0);

        // bad select on the 3-channel instance
        in_valid3 = 1; in_sel3 = 2'd3; in_code3 = 3'b111;
        step();
        in_valid3 = 0;
        check("badsel_err", 32'(err_sel3), 32'h1);
        check("badsel_valid", 32'(ch_valid3), 32'h0);
        check("badsel_ready", 32'(in_ready3), 32'h1);
        check("badsel_code", 32'(ch_code3), 32'h0);
        step();
        check("badsel_pulse", 32'(err_sel3), 32'h0);
        in_valid3 = 1; in_sel3 = 2'd2; in_code3 = 3'b110;
        step();
        in_valid3 = 0;
        check("ch2_code", 32'(ch_code3), 32'b110000000);
        check("ch2_valid", 32'(ch_valid3), 32'b100);
        check("ch2_noerr", 32'(err_sel3), 32'h0);
        ch_ack3 = 3'b100;
        step();
        ch_ack3 = 3'b000;
        check("ch2_ack_valid", 32'(ch_valid3), 32'h0);

        // reset mid-WAIT_ACK aborts silently
        in_valid = 1; in_sel = 1; in_code = 3'b100;
        step();
        in_valid = 0;
        check("pre_rst_valid", 32'(ch_valid), 32'b10);
        rst_n = 1'b0;
        #2;
        check("midrst_code", 32'(ch_code), 32'h0);
        check("midrst_valid", 32'(ch_valid), 32'h0);
        check("midrst_ready", 32'(in_ready), 32'h1);
        step();
        rst_n = 1'b1;
        saw_err = 1'b0;
        for (int k = 0; k < 7; k++) begin
            step();
            saw_err = saw_err | err_timeout | err_sel;
        end
        check("postrst_noerr", 32'(saw_err), 32'h0);
        check("postrst_ready", 32'(in_ready), 32'h1);
        check("postrst_valid", 32'(ch_valid), 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
